// File: rtl/freq_word_sync_if.sv
// freq_word_sync_if: bin request, commit and committed-FTW bus (FREQ_WORD_PENDING_EN adds m_ftw_pending)
interface freq_word_sync_if #(
  parameter int ADDR_W = 16,
  parameter int FTW_W  = 32,
  parameter int STEP_W = 7,
  parameter int NUM_CH = 2,
  parameter int CH_W   = 1
);
  logic [ADDR_W-1:0]        s_bin_data;
  logic [CH_W-1:0]          s_bin_ch;
  logic                     s_bin_valid;
  logic                     s_bin_ready;
  logic                     s_commit;
  logic [NUM_CH*FTW_W-1:0]  m_ftw_data;
  logic [NUM_CH*STEP_W-1:0] m_ftw_step;
  logic                     m_ftw_update;
  logic [NUM_CH-1:0]        m_ftw_sat;
  logic                     busy;
`ifdef FREQ_WORD_PENDING_EN
  logic [NUM_CH-1:0]        m_ftw_pending;
`endif
  modport master (
    output s_bin_data, s_bin_ch, s_bin_valid, s_commit,
    input  s_bin_ready, m_ftw_data, m_ftw_step, m_ftw_update, m_ftw_sat, busy
`ifdef FREQ_WORD_PENDING_EN
    , m_ftw_pending
`endif
  );
  modport slave (
    input  s_bin_data, s_bin_ch, s_bin_valid, s_commit,
    output s_bin_ready, m_ftw_data, m_ftw_step, m_ftw_update, m_ftw_sat, busy
`ifdef FREQ_WORD_PENDING_EN
    , m_ftw_pending
`endif
  );
endinterface

// File: rtl/freq_word_sync.sv
// freq_word_sync: multi-channel FFT-bin to DDS FTW converter with atomic commit on s_commit rising edge
// FREQ_WORD_PENDING_EN: commit copies only channels written since the last commit
module freq_word_sync #(
  parameter int ADDR_W     = 16,
  parameter int FTW_W      = 32,
  parameter int STEP_W     = 7,
  parameter int NUM_CH     = 2,
  parameter int CH_W       = 1,
  parameter int BIN_SHIFT  = 22,
  parameter int BIN_OFFSET = 3,
  parameter int FREQ_RESOL = 21474836
) (
  input logic             sys_clk,
  input logic             sys_rstn,
  freq_word_sync_if.slave bus
);
  localparam int TW = (ADDR_W + BIN_SHIFT > FTW_W) ? ADDR_W + BIN_SHIFT : FTW_W;
  localparam logic [FTW_W:0] RES = (FTW_W+1)'(FREQ_RESOL);
  localparam logic [FTW_W:0] RES2 = RES << 1;
  typedef enum logic {IDLE, CALC} state_t;
  state_t state, state_nx;
  logic [FTW_W:0] acc, acc_nx;
  logic [FTW_W-1:0] target, target_nx, target_in, wr_ftw;
  logic [STEP_W-1:0] step, step_nx, wr_step;
  logic [CH_W-1:0] ch, ch_nx;
  logic [ADDR_W-1:0] bin_adj;
  logic [TW-1:0] bin_full;
  logic accept, hit, top, wr, commit_q, commit_edge, upd;
  logic [NUM_CH-1:0][FTW_W-1:0] sh_ftw, ftw_q;
  logic [NUM_CH-1:0][STEP_W-1:0] sh_step, step_q;
  logic [NUM_CH-1:0] sh_sat, sat_q, mask;
  assign bus.s_bin_ready = sys_rstn && state == IDLE && !bus.s_commit;
  assign bus.busy = state == CALC;
  assign bus.m_ftw_data = ftw_q;
  assign bus.m_ftw_step = step_q;
  assign bus.m_ftw_sat = sat_q;
  assign bus.m_ftw_update = upd;
  assign accept = bus.s_bin_valid && bus.s_bin_ready;
  assign commit_edge = bus.s_commit && !commit_q;
  // target computed at full width so large bins clamp instead of wrapping
  assign bin_adj = bus.s_bin_data >= ADDR_W'(BIN_OFFSET) ? bus.s_bin_data - ADDR_W'(BIN_OFFSET) : bus.s_bin_data;
  assign bin_full = TW'(bin_adj) << BIN_SHIFT;
  assign target_in = bin_full > TW'({FTW_W{1'b1}}) ? '1 : bin_full[FTW_W-1:0];
  assign hit = acc > {1'b0, target};
  assign top = step == '1;
  assign wr = state == CALC && !bus.s_commit && (hit || top);
  assign wr_ftw = step >= STEP_W'(2) ? FTW_W'(acc - RES2) : '0;
  assign wr_step = step >= STEP_W'(2) ? step - STEP_W'(2) : '0;
  always_comb begin
    state_nx = state;
    acc_nx = acc;
    step_nx = step;
    ch_nx = ch;
    target_nx = target;
    if (state == IDLE) begin
      if (accept) begin
        ch_nx = bus.s_bin_ch;
        target_nx = target_in;
        acc_nx = '0;
        step_nx = '0;
        state_nx = 32'(bus.s_bin_ch) < NUM_CH ? CALC : IDLE;
      end
    end else if (bus.s_commit || hit || top) begin
      state_nx = IDLE;
    end else begin
      acc_nx = acc + RES;
      step_nx = step + STEP_W'(1);
    end
  end
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state <= IDLE;
      acc <= '0;
      step <= '0;
      ch <= '0;
      target <= '0;
      commit_q <= 1'b0;
      upd <= 1'b0;
      sh_ftw <= '0;
      sh_step <= '0;
      sh_sat <= '0;
      ftw_q <= '0;
      step_q <= '0;
      sat_q <= '0;
    end else begin
      state <= state_nx;
      acc <= acc_nx;
      step <= step_nx;
      ch <= ch_nx;
      target <= target_nx;
      commit_q <= bus.s_commit;
      upd <= commit_edge && |mask;
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr && ch == CH_W'(i)) begin
          sh_ftw[i] <= wr_ftw;
          sh_step[i] <= wr_step;
          sh_sat[i] <= !hit;
        end
        if (commit_edge && mask[i]) begin
          ftw_q[i] <= sh_ftw[i];
          step_q[i] <= sh_step[i];
          sat_q[i] <= sh_sat[i];
        end
      end
    end
  end
`ifdef FREQ_WORD_PENDING_EN
  logic [NUM_CH-1:0] pend;
  assign mask = pend;
  assign bus.m_ftw_pending = pend;
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      pend <= '0;
    end else if (commit_edge) begin
      pend <= '0;
    end else if (wr) begin
      for (int i = 0; i < NUM_CH; i++) if (ch == CH_W'(i)) pend[i] <= 1'b1;
    end
  end
`else
  assign mask = '1;
`endif
endmodule

// File: tb/tb_freq_word_sync.sv
// tb_freq_word_sync: directed and random checks of freq_word_sync against an arithmetic reference model
module tb_freq_word_sync;
  localparam longint R = 21474836;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int total = 0;
  int bad = 0;
  logic [31:0] sh_f[2], o_f[2];
  logic [6:0] sh_s[2], o_s[2];
  logic [1:0] sh_t, o_t, pend;

  always #5 clk = ~clk;

  freq_word_sync_if bus();
  freq_word_sync dut (.sys_clk(clk), .sys_rstn(rstn), .bus(bus));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".ftw"}, bus.m_ftw_data, {o_f[1], o_f[0]});
    check({tag, ".step"}, bus.m_ftw_step, {o_s[1], o_s[0]});
    check({tag, ".sat"}, bus.m_ftw_sat, o_t);
`ifdef FREQ_WORD_PENDING_EN
    check({tag, ".pend"}, bus.m_ftw_pending, pend);
`endif
  endtask

  // bins stepped k times until k*R exceeds the clamped target; saturate at 127
  function automatic void model(input int addr, output logic [31:0] f, output logic [6:0] s,
                                output logic sat, output int k);
    longint t;
    t = addr >= 3 ? addr - 3 : addr;
    t = t * 4194304;
    if (t > 64'hFFFF_FFFF) t = 64'hFFFF_FFFF;
    k = int'(t / R) + 1;
    sat = k > 127;
    if (sat) k = 127;
    f = k >= 2 ? 32'((k - 2) * R) : 32'd0;
    s = k >= 2 ? 7'(k - 2) : 7'd0;
  endfunction

  task automatic accept(input int ch, input int addr);
    int n = 0;
    while (!bus.s_bin_ready && n < 50) begin
      tick;
      n++;
    end
    check("ready_wait", bus.s_bin_ready, 1);
    bus.s_bin_ch = 1'(ch);
    bus.s_bin_data = 16'(addr);
    bus.s_bin_valid = 1'b1;
    tick;
    bus.s_bin_valid = 1'b0;
  endtask

  task automatic send(input int ch, input int addr);
    logic [31:0] f;
    logic [6:0] s;
    logic sat;
    int k;
    int n = 0;
    model(addr, f, s, sat, k);
    accept(ch, addr);
    while (bus.busy && n < 300) begin
      n++;
      tick;
    end
    check("calc_cycles", n, k + 1);
    sh_f[ch] = f;
    sh_s[ch] = s;
    sh_t[ch] = sat;
    pend[ch] = 1'b1;
`ifdef FREQ_WORD_PENDING_EN
    check("pend_set", bus.m_ftw_pending, pend);
`endif
  endtask

  task automatic commit(input string tag, input int hold);
    logic up;
`ifdef FREQ_WORD_PENDING_EN
    up = |pend;
`else
    up = 1'b1;
    pend = 2'b11;
`endif
    for (int i = 0; i < 2; i++) begin
      if (pend[i]) begin
        o_f[i] = sh_f[i];
        o_s[i] = sh_s[i];
        o_t[i] = sh_t[i];
      end
    end
    pend = 2'b00;
    bus.s_commit = 1'b1;
    tick;
    check({tag, ".upd"}, bus.m_ftw_update, up);
    check({tag, ".busy"}, bus.busy, 0);
    check_outs(tag);
    repeat (hold) begin
      tick;
      check({tag, ".upd_hold"}, bus.m_ftw_update, 0);
      check({tag, ".ready_hold"}, bus.s_bin_ready, 0);
    end
    bus.s_commit = 1'b0;
    tick;
    check({tag, ".upd_end"}, bus.m_ftw_update, 0);
    check_outs({tag, ".stable"});
  endtask

  initial begin
    bus.s_bin_data = '0;
    bus.s_bin_ch = '0;
    bus.s_bin_valid = 1'b0;
    bus.s_commit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sh_f[i] = '0;
      sh_s[i] = '0;
      o_f[i] = '0;
      o_s[i] = '0;
    end
    sh_t = '0;
    o_t = '0;
    pend = '0;
    repeat (3) tick;
    check("rst.ready", bus.s_bin_ready, 0);
    check("rst.busy", bus.busy, 0);
    check("rst.upd", bus.m_ftw_update, 0);
    check_outs("rst");
    rstn = 1'b1;
    tick;
    check("rel.ready", bus.s_bin_ready, 1);
    accept(0, 103);
    repeat (5) tick;
    check("mid.busy", bus.busy, 1);
    rstn = 1'b0;
    #1;
    check("mid.ready", bus.s_bin_ready, 0);
    check("mid.busy0", bus.busy, 0);
    check_outs("mid");
    tick;
    rstn = 1'b1;
    tick;
    check("mid.rel_ready", bus.s_bin_ready, 1);
    send(0, 103);
    commit("c103", 3);
    check("c103.const_ftw", bus.m_ftw_data[31:0], 386547048);
    check("c103.const_step", bus.m_ftw_step[6:0], 18);
    send(1, 13);
    commit("c13", 1);
    check("c13.ch1_ftw", bus.m_ftw_data[63:32], 0);
    check("c13.ch0_keep", bus.m_ftw_data[31:0], 386547048);
    send(1, 3);
    commit("c3", 1);
    commit("empty", 1);
    send(0, 1003);
    commit("c1003", 1);
    check("c1003.const_ftw", bus.m_ftw_data[31:0], 64'd2684354500);
    check("c1003.const_step", bus.m_ftw_step[6:0], 125);
    check("c1003.const_sat", bus.m_ftw_sat[0], 1);
    accept(0, 103);
    repeat (4) tick;
    commit("abort", 2);
    repeat (24) begin
      int ch, addr;
      ch = $urandom_range(0, 1);
      addr = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 1200);
      send(ch, addr);
      if ($urandom_range(0, 2) == 0) commit("rnd", $urandom_range(0, 2));
    end
    commit("final", 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/freq_word_sync.md
Name: freq_word_sync

Overview:
- Parametrised, multi-channel successor to the single-channel FFT-bin to DDS frequency-word converter.
- Accepts FFT peak-bin addresses tagged with a channel number over a valid/ready handshake.
- For each address, iteratively derives the down-converter frequency control word (FTW) and step count into a per-channel shadow register.
- On a commit edge from fft_detect's RAM-traverse flag, copies all shadows atomically to the outputs. Sits between fft_detect and the DDS/mixer config inputs.

Parameters:
- ADDR_W, 16, bin address width
- FTW_W, 32, frequency control word width
- STEP_W, 7, step counter width
- NUM_CH, 2, number of channels
- CH_W, 1, channel index width; must be at least clog2(NUM_CH)
- BIN_SHIFT, 22, address to FTW shift (K = addr·2^22 at 50 MHz)
- BIN_OFFSET, 3, bin offset subtracted when addr >= BIN_OFFSET
- FREQ_RESOL, 21474836, FTW increment per step (0.25 MHz)

Ports:
- sys_clk  in  1  clock
- sys_rstn  in  1  asynchronous active-low reset
- s_bin_data  in  ADDR_W  bin address
- s_bin_ch  in  CH_W  target channel
- s_bin_valid  in  1  request valid
- s_bin_ready  out  1  request accepted this cycle if valid is also high
- s_commit  in  1  fft_detect RAM_TRAV flag (level)
- m_ftw_data  out  NUM_CH·FTW_W  committed FTWs, channel 0 in the LSBs
- m_ftw_step  out  NUM_CH·STEP_W  committed step counts
- m_ftw_update  out  1  one-cycle pulse when a commit occurs
- m_ftw_sat  out  NUM_CH  committed per-channel step-saturation flags
- busy  out  1  high while in CALC

Behaviour:
- Reset: all outputs, shadows, accumulator and counters are 0. FSM returns to IDLE. s_bin_ready=0 during reset.
- s_bin_ready = (state==IDLE) && !s_commit. A request is accepted when valid && ready.
- Accept from IDLE:
  - Latch the channel.
  - target = (addr>=BIN_OFFSET ? addr-BIN_OFFSET : addr) << BIN_SHIFT, computed at full width, then clamped to 2^FTW_W-1.
  - acc=0, step=0. Go to CALC.
- CALC, evaluated each cycle with priority as listed:
  1. s_commit=1: abort. Shadow unchanged. Go to IDLE.
  2. acc>target: write shadow[ch] and go to IDLE.
     - If step>=2: FTW=acc-2·FREQ_RESOL, step=step-2.
     - Else: FTW=0, step=0.
     - sat shadow cleared.
  3. step==2^STEP_W-1: write the shadow using the same formula, set sat shadow[ch]=1, go to IDLE.
  4. Otherwise: acc+=FREQ_RESOL, step+=1.
- acc is FTW_W+1 bits wide and never wraps.
- Latency from accept to shadow write is k+2 cycles, where k is the final pre-subtraction step.
- Commit:
  - Detected on the rising edge of s_commit, using a registered copy of s_commit that resets to 0.
  - On that edge, copy all NUM_CH shadows (FTW, step, sat) to the outputs in one cycle. m_ftw_update pulses the next cycle with the outputs.
  - s_commit held high: no further copies. New requests are blocked.
- Simultaneous shadow write and commit edge: the abort rule applies, so the write is lost. Outputs take the previous shadow.
- Requests to a channel index >= NUM_CH are accepted and discarded. No shadow write. FSM stays in IDLE.
- Outputs are otherwise stable.

Optional Feature:
- Macro: FREQ_WORD_PENDING_EN.
- Defined:
  - Adds output m_ftw_pending[NUM_CH].
  - Bit set when its shadow is written; all bits cleared on a commit.
  - Commit copies only channels whose pending bit is set. Others keep their committed values.
  - m_ftw_update pulses only if at least one bit was pending.
- Undefined: port absent. Every commit copies all channels and always pulses m_ftw_update.

Test Plan:
- Reset mid-CALC (addr=103 accepted, assert sys_rstn=0 after 5 cycles) -> all outputs 0, state IDLE, ready=0 during reset and 1 after release.
- ch0 addr=103, then s_commit rise -> m_ftw_data[31:0]=386547048, step=18, sat=0; update pulses once; shadow written 22 cycles after accept.
- ch1 addr=13, then ch1 addr=3, then commit -> ch1 FTW=0, step=0 in both cases; ch0 unchanged.
- ch0 addr=1003 -> step saturates; after commit FTW=2684354500, step=125, m_ftw_sat[0]=1.
- Assert s_commit 4 cycles into ch0 addr=103 CALC -> abort, ch0 keeps old value, ready=0 while s_commit high, update pulses exactly once.
- With FREQ_WORD_PENDING_EN: write ch1 only, commit -> only ch1 changes, pending=2'b10 then 0. A second commit with nothing pending -> no update pulse.
